// File: rtl/max_result_serializer.sv
// Serializes the final alignment max {score, row, col} into OUT_WIDTH-wide
// beats, LSB first, over a valid/ready handshake.
module max_result_serializer #(
    parameter int SCORE_WIDTH    = 10,
    parameter int ROW_BITS_WIDTH = 9,
    parameter int COL_BITS_WIDTH = 9,
    parameter int OUT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      done_align,
    input  logic [SCORE_WIDTH-1:0]    max_score,
    input  logic [ROW_BITS_WIDTH-1:0] max_row,
    input  logic [COL_BITS_WIDTH-1:0] max_col,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      result_sent,
    output logic                      overrun
);

    localparam int REC_WIDTH = SCORE_WIDTH + ROW_BITS_WIDTH + COL_BITS_WIDTH;
    localparam int NUM_BEATS = (REC_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int PAD_WIDTH = NUM_BEATS * OUT_WIDTH;
    localparam int CNT_WIDTH = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(NUM_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PAD_WIDTH-1:0]   rec_q;
    logic [PAD_WIDTH-1:0]   rec_d;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   sent_q;
    logic                   overrun_q;
    logic                   at_last;
    logic                   xfer;
    logic [OUT_WIDTH-1:0]   beat_words [NUM_BEATS];

    // Record zero-extended to a whole number of beats so the top beat's spare MSBs read 0.
    always_comb begin
        rec_d = '0;
        rec_d[REC_WIDTH-1:0] = {max_score, max_row, max_col};
    end

    for (genvar i = 0; i < NUM_BEATS; i++) begin : g_beats
        assign beat_words[i] = rec_q[i*OUT_WIDTH +: OUT_WIDTH];
    end

    assign at_last = (count_q == LAST_BEAT);
    assign xfer    = (state_q == SEND) && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (done_align) state_d = SEND;
            SEND:    if (out_ready && at_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rec_q     <= '0;
            count_q   <= '0;
            sent_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sent_q  <= xfer && at_last;
            if (state_q == IDLE && done_align) begin
                rec_q   <= rec_d;
                count_q <= '0;
            end else if (xfer) begin
                count_q <= at_last ? '0 : count_q + CNT_WIDTH'(1);
            end
            // A done_align that arrives while a result is still going out is lost.
            if (state_q == SEND && done_align) overrun_q <= 1'b1;
        end
    end

    always_comb begin
        out_data = '0;
        if (state_q == SEND) out_data = beat_words[count_q];
    end

    assign out_valid   = (state_q == SEND);
    assign out_last    = (state_q == SEND) && at_last;
    assign busy        = (state_q == SEND);
    assign result_sent = sent_q;
    assign overrun     = overrun_q;

endmodule
